sc_note_matcher_array: RTL and testbench

- Parametrised successor to the per-note matcher bank. N independent note channels, each:
  - fetches its next expected note time from metadata;
  - arms on it;
  - grades the player's press edge against a ±WINDOW hit window.
- Emits per-channel hit and miss pulses, the signed timing error, and aggregate saturating hit/miss counters for the scoring/display path.
- Sits between the note-input decoder (NDATA) and the score logic; metadata comes from the song-chart reader.

---
 rtl/sc_note_matcher_array.sv | 120 ++++++++++++
 tb/tb_sc_note_matcher_array.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_note_matcher_array.sv
// Bank of independent note channels. Each channel fetches its next target time,
// arms on it, grades press edges against a +/-WINDOW window, and feeds saturating totals.
module sc_note_matcher_array #(
    parameter int NUM_NOTES = 37,
    parameter int TIME_W    = 16,
    parameter int WINDOW    = 8,
    parameter int COUNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [TIME_W-1:0]               song_time,
    input  logic [NUM_NOTES-1:0]            NDATA,
    input  logic [NUM_NOTES*TIME_W-1:0]     note_time,
    input  logic [NUM_NOTES-1:0]            note_time_valid,
    output logic [NUM_NOTES-1:0]            metadata_request,
    output logic [NUM_NOTES-1:0]            match_trigger,
    output logic [NUM_NOTES-1:0]            miss_trigger,
    output logic [NUM_NOTES*TIME_W-1:0]     match_time,
    output logic [NUM_NOTES*(TIME_W+1)-1:0] match_delta,
    output logic [COUNT_W-1:0]              hit_count,
    output logic [COUNT_W-1:0]              miss_count
);

    // Handshake: metadata_request[i] is a one-cycle pulse; the chart reader may answer
    // with note_time_valid[i] at any later cycle and the channel waits for it in REQ_WAIT.
    // A valid seen in any other state is ignored.
    typedef enum logic [1:0] {FETCH, REQ_WAIT, ARMED, DONE} chan_state_t;

    localparam int PC_W  = $clog2(NUM_NOTES + 1);
    localparam int SUM_W = ((COUNT_W > PC_W) ? COUNT_W : PC_W) + 1;
    localparam logic signed [TIME_W:0] WIN_POS  = (TIME_W+1)'(WINDOW);
    localparam logic signed [TIME_W:0] WIN_NEG  = -WIN_POS;
    localparam logic [TIME_W-1:0]      SENTINEL = '1;
    localparam logic [COUNT_W-1:0]     CNT_MAX  = '1;

    chan_state_t              state_q [NUM_NOTES];
    chan_state_t              state_d [NUM_NOTES];
    logic [TIME_W-1:0]        target_q [NUM_NOTES];
    logic signed [TIME_W:0]   diff [NUM_NOTES];
    logic [NUM_NOTES-1:0]     note_prev;
    logic [NUM_NOTES-1:0]     press;
    logic [NUM_NOTES-1:0]     hit;
    logic [NUM_NOTES-1:0]     miss;
    logic [SUM_W-1:0]         hit_sum;
    logic [SUM_W-1:0]         miss_sum;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_NOTES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_NOTES; k++) begin
            c = c + PC_W'(v[k]);
        end
        return c;
    endfunction

    always_comb begin
        press = NDATA & ~note_prev;
        hit   = '0;
        miss  = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            state_d[i] = state_q[i];
            // Zero-extended subtraction keeps the early bound from wrapping for small targets.
            diff[i] = $signed({1'b0, song_time}) - $signed({1'b0, target_q[i]});
            case (state_q[i])
                FETCH: state_d[i] = REQ_WAIT;
                REQ_WAIT: begin
                    if (note_time_valid[i]) begin
                        state_d[i] = (note_time[TIME_W*i +: TIME_W] == SENTINEL) ? DONE : ARMED;
                    end
                end
                ARMED: begin
                    if (press[i] && (diff[i] >= WIN_NEG) && (diff[i] <= WIN_POS)) begin
                        hit[i]     = 1'b1;
                        state_d[i] = FETCH;
                    end else if (diff[i] > WIN_POS) begin
                        miss[i]    = 1'b1;
                        state_d[i] = FETCH;
                    end
                end
                default: state_d[i] = state_q[i];
            endcase
        end
        hit_sum  = SUM_W'(hit_count)  + SUM_W'(popcount(match_trigger));
        miss_sum = SUM_W'(miss_count) + SUM_W'(popcount(miss_trigger));
    end

    always_ff @(posedge clk) begin
        note_prev <= NDATA;
        if (reset) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                state_q[i]  <= FETCH;
                target_q[i] <= '0;
            end
            metadata_request <= '0;
            match_trigger    <= '0;
            miss_trigger     <= '0;
            match_time       <= '0;
            match_delta      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                state_q[i]          <= state_d[i];
                metadata_request[i] <= (state_q[i] == FETCH);
                if ((state_q[i] == REQ_WAIT) && note_time_valid[i]) begin
                    target_q[i] <= note_time[TIME_W*i +: TIME_W];
                end
                if (hit[i]) begin
                    match_time[TIME_W*i +: TIME_W]           <= song_time;
                    match_delta[(TIME_W+1)*i +: (TIME_W+1)]  <= diff[i];
                end
            end
            match_trigger <= hit;
            miss_trigger  <= miss;
            hit_count  <= (hit_sum  > SUM_W'(CNT_MAX)) ? CNT_MAX : hit_sum[COUNT_W-1:0];
            miss_count <= (miss_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : miss_sum[COUNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_sc_note_matcher_array.sv
// Bench for sc_note_matcher_array: directed vector table, hand sequences for reset,
// simultaneous hits, saturation and DONE, then randomized play against a timeline model.
module tb_sc_note_matcher_array;

    localparam int N   = 4;
    localparam int TW  = 16;
    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int INF = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [TW-1:0]         song_time;
    logic [N-1:0]          ndata;
    logic [N*TW-1:0]       note_time;
    logic [N-1:0]          valid;
    logic [N-1:0]          req, match, miss;
    logic [N*TW-1:0]       mt;
    logic [N*(TW+1)-1:0]   md;
    logic [CW-1:0]         hc, mc;
    logic [N-1:0]          req_s, match_s, miss_s;
    logic [N*TW-1:0]       mt_s;
    logic [N*(TW+1)-1:0]   md_s;
    logic [1:0]            hc_s, mc_s;

    sc_note_matcher_array #(.NUM_NOTES(N), .TIME_W(TW), .WINDOW(W), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .song_time(song_time), .NDATA(ndata),
        .note_time(note_time), .note_time_valid(valid),
        .metadata_request(req), .match_trigger(match), .miss_trigger(miss),
        .match_time(mt), .match_delta(md), .hit_count(hc), .miss_count(mc)
    );

    sc_note_matcher_array #(.NUM_NOTES(N), .TIME_W(TW), .WINDOW(W), .COUNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .song_time(song_time), .NDATA(ndata),
        .note_time(note_time), .note_time_valid(valid),
        .metadata_request(req_s), .match_trigger(match_s), .miss_trigger(miss_s),
        .match_time(mt_s), .match_delta(md_s), .hit_count(hc_s), .miss_count(mc_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Timeline model: cycle numbers at which each channel requests and starts grading.
    int m_target [N];
    int m_eval_from [N];
    int m_req_edge [N];
    bit m_done [N];
    int exp_mt [N];
    int exp_md [N];
    int hit_tot, miss_tot, last_hits, last_miss;
    logic [N-1:0] exp_req, exp_match, exp_miss, prev_nd;

    // Chart reader stand-in.
    int chart [N][$];
    bit pending [N];
    int delay_left [N];
    int max_delay = 0;
    bit spurious_en = 1'b0;

    typedef struct {
        int ch; int target; int start_t; int p0; int p1;
        int exp_hits; int exp_misses; int exp_mt; int exp_md;
    } vec_t;
    vec_t vecs [8];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] press);
        int d;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_req_edge[i] = edge_n + 1;
                m_eval_from[i] = INF;
                m_done[i] = 1'b0;
                exp_mt[i] = 0;
                exp_md[i] = 0;
                pending[i] = 1'b0;
            end
            exp_req = '0; exp_match = '0; exp_miss = '0;
            hit_tot = 0; miss_tot = 0; last_hits = 0; last_miss = 0;
            return;
        end
        hit_tot  += last_hits;
        miss_tot += last_miss;
        exp_req = '0; exp_match = '0; exp_miss = '0;
        for (int i = 0; i < N; i++) begin
            if (edge_n == m_req_edge[i]) exp_req[i] = 1'b1;
            if (!m_done[i] && edge_n >= m_eval_from[i]) begin
                d = int'(song_time) - m_target[i];
                if (press[i] && d >= -W && d <= W) begin
                    exp_match[i] = 1'b1;
                    exp_mt[i] = int'(song_time);
                    exp_md[i] = d;
                    m_eval_from[i] = INF;
                    m_req_edge[i] = edge_n + 1;
                end else if (d > W) begin
                    exp_miss[i] = 1'b1;
                    m_eval_from[i] = INF;
                    m_req_edge[i] = edge_n + 1;
                end
            end
        end
        last_hits = $countones(exp_match);
        last_miss = $countones(exp_miss);
    endtask

    task automatic compare_all();
        logic [N*TW-1:0]     mt_v;
        logic [N*(TW+1)-1:0] md_v;
        for (int i = 0; i < N; i++) begin
            mt_v[TW*i +: TW] = TW'(exp_mt[i]);
            md_v[(TW+1)*i +: (TW+1)] = (TW+1)'(exp_md[i]);
        end
        check("metadata_request", 72'(req), 72'(exp_req));
        check("match_trigger", 72'(match), 72'(exp_match));
        check("miss_trigger", 72'(miss), 72'(exp_miss));
        check("hit_count", 72'(hc), 72'(sat(hit_tot, 65535)));
        check("miss_count", 72'(mc), 72'(sat(miss_tot, 65535)));
        check("hit_count_sat2", 72'(hc_s), 72'(sat(hit_tot, 3)));
        check("miss_count_sat2", 72'(mc_s), 72'(sat(miss_tot, 3)));
        check("match_time", 72'(mt), 72'(mt_v));
        check("match_delta", 72'(md), 72'(md_v));
    endtask

    task automatic respond();
        int v;
        valid = '0;
        note_time = {$urandom(), $urandom()};
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                pending[i] = 1'b1;
                delay_left[i] = $urandom_range(0, max_delay);
            end
            if (pending[i]) begin
                if (delay_left[i] == 0) begin
                    v = (chart[i].size() > 0) ? chart[i].pop_front() : 'hFFFF;
                    valid[i] = 1'b1;
                    note_time[TW*i +: TW] = TW'(v);
                    m_target[i] = v;
                    if (v == 'hFFFF) m_done[i] = 1'b1;
                    else m_eval_from[i] = edge_n + 2;
                    pending[i] = 1'b0;
                end else begin
                    delay_left[i]--;
                end
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                valid[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] press;
        press = ndata & ~prev_nd;
        @(posedge clk);
        edge_n++;
        model_edge(press);
        #1;
        compare_all();
        prev_nd = ndata;
        respond();
    endtask

    task automatic do_reset(input int cycles, input logic [N-1:0] nd);
        for (int i = 0; i < N; i++) chart[i].delete();
        reset = 1'b1;
        ndata = nd;
        song_time = '0;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    initial begin
        logic [TW:0] md_req;
        int t;
        reset = 1'b1; song_time = '0; ndata = '0; valid = '0; note_time = '0;
        prev_nd = '0;
        for (int i = 0; i < N; i++) begin
            pending[i] = 1'b0; delay_left[i] = 0; m_target[i] = 0;
            m_eval_from[i] = INF; m_req_edge[i] = INF; m_done[i] = 1'b0;
        end

        // Directed single-channel vectors.
        vecs[0] = '{0, 100, 80, 95, -1, 1, 0, 95, -5};
        vecs[1] = '{1, 100, 80, 90, 108, 1, 0, 108, 8};
        vecs[2] = '{1, 100, 80, 109, -1, 0, 1, 0, 0};
        vecs[3] = '{2, 50, 30, 60, -1, 0, 1, 0, 0};
        vecs[4] = '{0, 0, 0, 0, -1, 1, 0, 0, 0};
        vecs[5] = '{3, 20, 0, 12, -1, 1, 0, 12, -8};
        vecs[6] = '{3, 20, 0, 11, -1, 0, 1, 0, 0};
        vecs[7] = '{2, 3, 0, 0, -1, 1, 0, 0, -3};
        for (int k = 0; k < 8; k++) begin
            do_reset(2, '0);
            chart[vecs[k].ch].push_back(vecs[k].target);
            song_time = TW'(vecs[k].start_t);
            repeat (4) step();
            for (t = vecs[k].start_t; t <= vecs[k].target + W + 3; t++) begin
                song_time = TW'(t);
                ndata = ((t == vecs[k].p0) || (t == vecs[k].p1)) ? N'(1 << vecs[k].ch) : '0;
                step();
            end
            ndata = '0;
            repeat (2) step();
            md_req = (TW+1)'(vecs[k].exp_md);
            check("vec_hits", 72'(hc), 72'(vecs[k].exp_hits));
            check("vec_misses", 72'(mc), 72'(vecs[k].exp_misses));
            check("vec_match_time", 72'(mt[TW*vecs[k].ch +: TW]), 72'(vecs[k].exp_mt));
            check("vec_match_delta", 72'(md[(TW+1)*vecs[k].ch +: (TW+1)]), 72'(md_req));
        end

        // Reset with a held note, then all channels hit on the same cycle.
        do_reset(3, 4'b0001);
        for (int i = 0; i < N; i++) chart[i].push_back(200);
        chart[0].push_back(300);
        song_time = 16'd190;
        step();
        check("post_reset_req", 72'(req), 72'(4'hF));
        check("post_reset_no_match", 72'(match), 72'(4'h0));
        ndata = '0;
        repeat (4) step();
        for (t = 191; t < 200; t++) begin
            song_time = TW'(t);
            step();
        end
        song_time = 16'd200;
        ndata = 4'hF;
        step();
        check("all_hit", 72'(match), 72'(4'hF));
        ndata = '0;
        step();
        check("all_hit_count", 72'(hc), 72'(4));
        check("all_hit_sat2", 72'(hc_s), 72'(3));
        check("all_rerequest", 72'(req), 72'(4'hF));

        // Channels 1..3 run out of chart and go inert; channel 0 stays armed on 300.
        repeat (4) step();
        for (t = 201; t < 260; t++) begin
            song_time = TW'(t);
            ndata = (t % 3 == 0) ? 4'b1110 : 4'b0000;
            step();
            check("done_no_req", 72'(req[3:1]), 72'(3'b000));
        end
        check("done_inert_hits", 72'(hc), 72'(4));
        reset = 1'b1;
        step();
        check("mid_reset_hits", 72'(hc), 72'(0));
        check("mid_reset_time", 72'(mt), 72'(0));
        reset = 1'b0;
        ndata = '0;
        step();
        check("mid_reset_rerequest", 72'(req), 72'(4'hF));

        // Randomized play with delayed answers and stray valids.
        max_delay = 3;
        spurious_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            do_reset(2, N'($urandom_range(0, 15)));
            for (int i = 0; i < N; i++) begin
                t = $urandom_range(0, 20);
                for (int k = 0; k < 30; k++) begin
                    chart[i].push_back(t);
                    t += $urandom_range(4, 40);
                end
            end
            for (int c = 0; c < 900; c++) begin
                song_time = song_time + TW'($urandom_range(0, 2));
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 3) == 0) ndata[i] = ~ndata[i];
                end
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
